rc_meas_sequencer: RTL
======================

// Module: rc_meas_sequencer
// PURPOSE
//  Sequences repeated RC charge/discharge measurements for the RC time-to-digital front end.
//  Drives step_set to excite the RC network and synchronises the comparator return step_input.
//  Counts charge time in clk cycles and averages 2**AVG_LOG2 samples.
//  Presents one result with a valid/ready handshake to the downstream resistance calculation.
// PARAMETERS
//  CNT_W            24          width of per-sample charge counter
//  AVG_LOG2         2           log2 of samples averaged per result (0 = single sample)
//  DISCHARGE_CYCLES 1024        cycles step_set is held low before each charge phase
//  MAX_COUNT        2**CNT_W-1  charge-count timeout limit
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  start         in   1      single-cycle request to begin a result; ignored unless IDLE
//  continuous    in   1      1 = automatically restart after each accepted result
//  step_input    in   1      asynchronous RC comparator output (1 = threshold crossed)
//  step_set      out  1      RC excitation (1 = charge, 0 = discharge)
//  busy          out  1      1 in any state other than IDLE
//  result        out  CNT_W  averaged charge time in clk cycles
//  result_valid  out  1      result is valid; held until result_ready
//  result_ready  in   1      downstream accepts result when high with result_valid
//  timeout_err   out  1      sticky: last result aborted by timeout
// BEHAVIOUR
//  Clock and reset
//   - One clock; reset is synchronous and active-high.
//   - Reset forces state IDLE and clears step_set, busy, result, result_valid, timeout_err,
//     both sync flops, the counters and the accumulator to 0.
//   - Reset mid-measurement: step_set is 0 after the next edge; no partial result is output.
//  Synchroniser
//   - step_input passes through 2 flops to give step_sync.
//   - Only step_sync is used internally.
//  States: IDLE -> DISCHARGE -> CHARGE -> (DISCHARGE | DONE) -> (IDLE | DISCHARGE)
//  IDLE
//   - step_set=0.
//   - Leaves on start=1 or continuous=1.
//   - On leaving: clear accumulator and sample index, clear timeout_err, load discharge
//     counter, go to DISCHARGE.
//  DISCHARGE
//   - step_set=0 for exactly DISCHARGE_CYCLES cycles.
//   - In the last cycle:
//     - step_sync=0: go to CHARGE with charge count=0.
//     - step_sync=1 (RC failed to discharge): set timeout_err, result=all ones, go to DONE.
//  CHARGE
//   - step_set=1.
//   - Each cycle with step_sync=0: count increments by 1.
//   - First cycle with step_sync=1: capture count (no increment) and add it to the
//     accumulator (width CNT_W+AVG_LOG2, cannot overflow).
//     - If sample index < 2**AVG_LOG2-1: index++, go to DISCHARGE.
//     - Otherwise go to DONE.
//   - Count reaches MAX_COUNT with step_sync still 0: set timeout_err, result=all ones,
//     go to DONE.
//   - Timeout has priority over a coincident step_sync.
//  DONE
//   - step_set=0.
//   - Entry cycle: load result = accumulator >> AVG_LOG2 (truncating) unless the timeout
//     path applies; assert result_valid.
//   - result and result_valid are stable while result_valid=1 and result_ready=0.
//   - On result_valid & result_ready: result_valid=0 on the next edge.
//     - continuous=1: go to DISCHARGE (accumulator cleared, timeout_err cleared).
//     - Otherwise go to IDLE.
//  Other rules
//   - result holds its value after the handshake until the next result loads.
//   - start while busy is ignored; it is not queued.
//   - continuous dropping mid-run finishes the current result, then returns to IDLE.
//  Latency
//   - A step_input rise meeting setup before edge e is seen as step_sync=1 in the cycle
//     after edge e+1.
//   - The sample therefore includes 2 cycles of synchroniser delay; no compensation is applied.
// TESTING
//  1. AVG_LOG2=0, DISCHARGE_CYCLES=4; start; raise step_input 10 cycles into CHARGE
//     -> result=12, result_valid=1, timeout_err=0.
//  2. AVG_LOG2=2, step_input delays 10/11/12/13 CHARGE cycles -> samples 12/13/14/15;
//     result=13; exactly 4 step_set rising edges.
//  3. CNT_W=8, step_input held 0 -> after 255 CHARGE cycles: timeout_err=1, result=8'hFF,
//     step_set=0.
//  4. result_ready=0 for 20 cycles after valid -> result and result_valid stable; ready pulse
//     -> valid=0 next cycle, IDLE.
//  5. continuous=1, ready tied 1 -> back-to-back results with a 4-cycle DISCHARGE between
//     them; start pulses during CHARGE have no effect.
//  6. reset asserted mid-CHARGE -> next cycle: step_set=0, busy=0, result_valid=0,
//     timeout_err=0.

Source files
------------

// File: rtl/rc_meas_sequencer.sv
// RC charge/discharge measurement sequencer: excites the RC network, times the synchronised
// comparator return in clk cycles and averages 2**AVG_LOG2 samples into one handshaked result.
module rc_meas_sequencer #(
  parameter int CNT_W            = 24,
  parameter int AVG_LOG2         = 2,
  parameter int DISCHARGE_CYCLES = 1024,
  parameter logic [CNT_W-1:0] MAX_COUNT = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             step_input,
  output logic             step_set,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout_err
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int DIS_W = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [DIS_W-1:0] DIS_LOAD = DIS_W'(DISCHARGE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, DISCHARGE, CHARGE, DONE} state_t;

  state_t             state_reg;
  logic [1:0]         sync_reg;
  logic               step_sync;
  logic [CNT_W-1:0]   count_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   acc_sum;
  logic [IDX_W-1:0]   idx_reg;
  logic [DIS_W-1:0]   dis_cnt_reg;

  // Two-flop synchroniser for the asynchronous comparator output
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], step_input};
    end
  end

  assign step_sync = sync_reg[1];
  assign acc_sum   = acc_reg + ACC_W'(count_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      step_set     <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      count_reg    <= '0;
      acc_reg      <= '0;
      idx_reg      <= '0;
      dis_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          step_set <= 1'b0;
          if (start || continuous) begin
            acc_reg     <= '0;
            idx_reg     <= '0;
            timeout_err <= 1'b0;
            dis_cnt_reg <= DIS_LOAD;
            busy        <= 1'b1;
            state_reg   <= DISCHARGE;
          end
        end
        DISCHARGE: begin
          if (dis_cnt_reg != '0) begin
            dis_cnt_reg <= dis_cnt_reg - DIS_W'(1);
          end else if (step_sync) begin
            // Comparator still high after the full discharge: the RC never discharged
            timeout_err  <= 1'b1;
            result       <= '1;
            result_valid <= 1'b1;
            state_reg    <= DONE;
          end else begin
            count_reg <= '0;
            step_set  <= 1'b1;
            state_reg <= CHARGE;
          end
        end
        CHARGE: begin
          if (count_reg == MAX_COUNT) begin
            timeout_err  <= 1'b1;
            result       <= '1;
            result_valid <= 1'b1;
            step_set     <= 1'b0;
            state_reg    <= DONE;
          end else if (step_sync) begin
            acc_reg  <= acc_sum;
            step_set <= 1'b0;
            if (idx_reg < IDX_LAST) begin
              idx_reg     <= idx_reg + IDX_W'(1);
              dis_cnt_reg <= DIS_LOAD;
              state_reg   <= DISCHARGE;
            end else begin
              result       <= CNT_W'(acc_sum >> AVG_LOG2);
              result_valid <= 1'b1;
              state_reg    <= DONE;
            end
          end else begin
            count_reg <= count_reg + CNT_W'(1);
          end
        end
        DONE: begin
          step_set <= 1'b0;
          if (result_ready) begin
            result_valid <= 1'b0;
            if (continuous) begin
              acc_reg     <= '0;
              idx_reg     <= '0;
              timeout_err <= 1'b0;
              dis_cnt_reg <= DIS_LOAD;
              state_reg   <= DISCHARGE;
            end else begin
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
